ma_seq: RTL and testbench

- Parametrised memory-reference sequencer; successor to the fixed 32K `ma` unit.
- Computes effective addresses for PDP-8 memory-reference instructions: page/zero-page, indirect, auto-index.
- Runs the memory cycles of AND/TAD/ISZ/DCA/JMS/JMP and the front-panel load/deposit/examine operations.
- Talks to an external variable-latency RAM through a req/ack handshake, so wider field counts and slower memories need no sequencer change.

---
 rtl/ma_seq_pkg.sv | 36 +++
 rtl/ma_bus_if.sv | 50 +++++
 rtl/ma_seq.sv | 214 +++++++++++++++++++++
 tb/tb_ma_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_seq_pkg.sv
// Shared constants for the memory-reference sequencer.
package ma_seq_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  localparam logic [11:0] AI_LO_DEF = 12'o0010;
  localparam logic [11:0] AI_HI_DEF = 12'o0017;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IND_RD,
    S_IND_WR,
    S_OP_RD,
    S_OP_WR,
    S_FIN
  } state_t;

  // Operand cycle that follows once the pointer is known.
  function automatic state_t operand_state(input logic [2:0] op);
    state_t s;
    case (op)
      OP_AND, OP_TAD, OP_ISZ: s = S_OP_RD;
      OP_DCA, OP_JMS:         s = S_OP_WR;
      default:                s = S_FIN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ma_bus_if.sv
// Request/acknowledge holding register for the external memory.
module ma_bus_if
  import ma_seq_pkg::*;
#(
  parameter int unsigned FIELD_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_issue,
  input  logic               i_we,
  input  logic [FIELD_W+11:0] i_addr,
  input  logic [11:0]        i_wdata,
  input  logic               i_ack,
  output logic               o_req,
  output logic               o_we,
  output logic [FIELD_W+11:0] o_addr,
  output logic [11:0]        o_wdata,
  output logic               o_complete
);

  logic               r_req;
  logic               r_we;
  logic [FIELD_W+11:0] r_addr;
  logic [11:0]        r_wdata;

  // An ack only counts while a request is outstanding.
  assign o_complete = r_req & i_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (o_complete) begin
      r_req <= 1'b0;
    end else if (i_issue && !r_req) begin
      r_req   <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  assign o_req   = r_req;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/ma_seq.sv
// PDP-8 memory-reference sequencer with front-panel load/deposit/examine.
module ma_seq
  import ma_seq_pkg::*;
#(
  parameter int unsigned FIELD_W = 3,
  parameter logic [11:0] AI_LO   = AI_LO_DEF,
  parameter logic [11:0] AI_HI   = AI_HI_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [11:0]        instruction,
  input  logic [11:0]        pc,
  input  logic [11:0]        ac,
  input  logic [11:0]        sr,
  input  logic [FIELD_W-1:0] IF,
  input  logic [FIELD_W-1:0] DF,
  input  logic               addr_loadd,
  input  logic               depd,
  input  logic               examd,
  output logic               mem_req,
  output logic               mem_we,
  output logic [FIELD_W+11:0] mem_addr,
  output logic [11:0]        mem_wdata,
  input  logic [11:0]        mem_rdata,
  input  logic               mem_ack,
  output logic [FIELD_W+11:0] eaddr,
  output logic [11:0]        mdout,
  output logic               skip,
  output logic               jump,
  output logic               busy,
  output logic               done
);

  localparam int unsigned AW = FIELD_W + 12;

  // PDP-8 bit 0 is the MSB: [0:2] -> [11:9], [3] -> [8], [4] -> [7], [5:11] -> [6:0].
  logic [2:0]  w_opcode;
  logic        w_ind;
  logic [11:0] w_base;
  logic        w_ai;
  logic [11:0] w_rd_inc;

  assign w_opcode = instruction[11:9];
  assign w_ind    = instruction[8];
  assign w_base   = {instruction[7] ? pc[11:7] : 5'b0, instruction[6:0]};
  assign w_ai     = (w_base >= AI_LO) && (w_base <= AI_HI);
  assign w_rd_inc = mem_rdata + 12'd1;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic                r_panel;
  logic                r_ai;
  logic [11:0]         r_base;
  logic [FIELD_W-1:0]  r_if;
  logic [FIELD_W-1:0]  r_field;
  logic [11:0]         r_ptr;
  logic [11:0]         r_wdata;
  logic [AW-1:0]       r_eaddr;
  logic [11:0]         r_mdout;
  logic                r_skip;
  logic                r_jump;
  logic [AW-1:0]       r_panel_addr;

  logic                w_issue;
  logic                w_we;
  logic [AW-1:0]       w_addr;
  logic [11:0]         w_wdata;
  logic                w_complete;

  ma_bus_if #(.FIELD_W(FIELD_W)) u_bus (
    .clk        (clk),
    .reset      (reset),
    .i_issue    (w_issue),
    .i_we       (w_we),
    .i_addr     (w_addr),
    .i_wdata    (w_wdata),
    .i_ack      (mem_ack),
    .o_req      (mem_req),
    .o_we       (mem_we),
    .o_addr     (mem_addr),
    .o_wdata    (mem_wdata),
    .o_complete (w_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Each memory state issues once the previous request has dropped, then waits for completion.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_we    = 1'b0;
    w_addr  = r_eaddr;
    w_wdata = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_opcode == OP_IOT || w_opcode == OP_OPR) w_next = S_FIN;
          else if (w_ind)                               w_next = S_IND_RD;
          else                                          w_next = operand_state(w_opcode);
        end else if (!addr_loadd && depd) begin
          w_next = S_OP_WR;
        end else if (!addr_loadd && examd) begin
          w_next = S_OP_RD;
        end
      end
      S_IND_RD: begin
        w_issue = !mem_req;
        w_addr  = {r_if, r_base};
        if (w_complete) w_next = r_ai ? S_IND_WR : operand_state(r_op);
      end
      S_IND_WR: begin
        w_issue = !mem_req;
        w_we    = 1'b1;
        w_addr  = {r_if, r_base};
        w_wdata = r_ptr;
        if (w_complete) w_next = operand_state(r_op);
      end
      S_OP_RD: begin
        w_issue = !mem_req;
        if (w_complete) w_next = (!r_panel && r_op == OP_ISZ) ? S_OP_WR : S_FIN;
      end
      S_OP_WR: begin
        w_issue = !mem_req;
        w_we    = 1'b1;
        if (w_complete) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_eaddr doubles as the operand address for both instruction and panel cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= '0;
      r_panel      <= 1'b0;
      r_ai         <= 1'b0;
      r_base       <= '0;
      r_if         <= '0;
      r_field      <= '0;
      r_ptr        <= '0;
      r_wdata      <= '0;
      r_eaddr      <= '0;
      r_mdout      <= '0;
      r_skip       <= 1'b0;
      r_jump       <= 1'b0;
      r_panel_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= w_opcode;
            r_panel <= 1'b0;
            r_ai    <= w_ai;
            r_base  <= w_base;
            r_if    <= IF;
            r_field <= (w_ind && w_opcode < OP_JMS) ? DF : IF;
            r_wdata <= (w_opcode == OP_JMS) ? pc + 12'd1 : ac;
            r_skip  <= 1'b0;
            r_jump  <= (w_opcode == OP_JMS) || (w_opcode == OP_JMP);
            if (!w_ind && w_opcode < OP_IOT) r_eaddr <= {IF, w_base};
          end else if (addr_loadd) begin
            r_panel_addr <= {IF, sr};
            r_eaddr      <= {IF, sr};
          end else if (depd || examd) begin
            r_panel <= 1'b1;
            r_wdata <= sr;
            r_eaddr <= r_panel_addr;
            r_skip  <= 1'b0;
            r_jump  <= 1'b0;
          end
        end
        S_IND_RD: begin
          if (w_complete) begin
            r_ptr   <= w_rd_inc;
            r_eaddr <= {r_field, r_ai ? w_rd_inc : mem_rdata};
          end
        end
        S_OP_RD: begin
          if (w_complete) begin
            r_mdout <= mem_rdata;
            r_wdata <= w_rd_inc;
            if (r_panel) r_panel_addr <= {r_panel_addr[AW-1:12], r_panel_addr[11:0] + 12'd1};
          end
        end
        S_OP_WR: begin
          if (w_complete) begin
            r_mdout <= r_wdata;
            if (r_panel) begin
              r_panel_addr <= {r_panel_addr[AW-1:12], r_panel_addr[11:0] + 12'd1};
            end else begin
              r_skip <= (r_op == OP_ISZ) && (r_wdata == '0);
              if (r_op == OP_JMS) r_eaddr <= {r_eaddr[AW-1:12], r_eaddr[11:0] + 12'd1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign eaddr = r_eaddr;
  assign mdout = r_mdout;
  assign skip  = r_skip;
  assign jump  = r_jump;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_FIN);

endmodule

// File: tb/tb_ma_seq.sv
// Randomised bench for ma_seq against a transaction-level reference model.
module tb_ma_seq;

  localparam int FW = 3;
  localparam int AW = FW + 12;

  logic          clk = 1'b0;
  logic          reset, start, addr_loadd, depd, examd;
  logic [11:0]   instruction, pc, ac, sr;
  logic [FW-1:0] IF, DF;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr, eaddr;
  logic [11:0]   mem_wdata, mem_rdata, mdout;
  logic          skip, jump, busy, done;

  always #5 clk = ~clk;

  ma_seq #(.FIELD_W(FW)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction), .pc(pc), .ac(ac),
    .sr(sr), .IF(IF), .DF(DF), .addr_loadd(addr_loadd), .depd(depd), .examd(examd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .eaddr(eaddr), .mdout(mdout),
    .skip(skip), .jump(jump), .busy(busy), .done(done)
  );

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [11:0] data; } tx_t;

  logic [11:0] bus_mem [0:32767];
  logic [11:0] ref_mem [0:32767];
  tx_t exp_q[$];
  tx_t obs_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0]   exp_md    = '0;
  logic [AW-1:0] exp_ea    = '0;
  logic [AW-1:0] exp_panel = '0;
  bit            exp_skip, exp_jump, chk_ea;

  int lat       = 1;
  bit rand_lat  = 0;
  bit resp_en   = 1;
  bit force_ack = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Memory responder: acks after a programmable number of request cycles.
  initial begin
    int  cnt;
    int  cur_lat;
    bit  prev_ack;
    tx_t held;
    tx_t cur;
    cnt = 0; cur_lat = 1; prev_ack = 0; held = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = force_ack;
      if (prev_ack && !reset) check_eq("req_drop", 32'(mem_req), 32'(0));
      prev_ack = 0;
      cur = {mem_we, mem_addr, mem_wdata};
      if (reset || !mem_req || !resp_en) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 1) begin
          held    = cur;
          cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
        end else begin
          check_eq("bus_stable", 32'(cur), 32'(held));
        end
        if (cnt >= cur_lat) begin
          mem_ack  = 1'b1;
          prev_ack = 1;
          cnt      = 0;
          if (mem_we) begin
            bus_mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = bus_mem[mem_addr];
            cur.data  = mem_rdata;
          end
          obs_q.push_back(cur);
        end
      end
    end
  end

  task automatic push_tx(input logic we, input logic [AW-1:0] a, input logic [11:0] d);
    tx_t t;
    t.we = we; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic set_mem(input logic [AW-1:0] a, input logic [11:0] d);
    bus_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Reference: the instruction's memory cycles, in order, straight from the addressing rules.
  task automatic model_memref(input logic [11:0] ins, input logic [11:0] pcv, input logic [11:0] acv,
                              input logic [FW-1:0] ifv, input logic [FW-1:0] dfv);
    int            op;
    logic [11:0]   base, ptr, v, nxt;
    logic [FW-1:0] fld;
    logic [AW-1:0] ea;
    op = int'(ins[11:9]);
    base = ins[7] ? {pcv[11:7], ins[6:0]} : {5'd0, ins[6:0]};
    exp_skip = 0; exp_jump = 0; chk_ea = 0;
    if (op >= 6) return;
    chk_ea = 1;
    if (ins[8]) begin
      ptr = ref_mem[{ifv, base}];
      push_tx(1'b0, {ifv, base}, ptr);
      if (base >= 12'o0010 && base <= 12'o0017) begin
        ptr = ptr + 12'd1;
        ref_mem[{ifv, base}] = ptr;
        push_tx(1'b1, {ifv, base}, ptr);
      end
      fld = (op >= 4) ? ifv : dfv;
    end else begin
      ptr = base;
      fld = ifv;
    end
    ea = {fld, ptr};
    exp_ea = ea;
    case (op)
      0, 1: begin v = ref_mem[ea]; push_tx(1'b0, ea, v); exp_md = v; end
      2: begin
        v = ref_mem[ea]; push_tx(1'b0, ea, v);
        v = v + 12'd1; ref_mem[ea] = v; push_tx(1'b1, ea, v);
        exp_md = v; exp_skip = (v == 12'd0);
      end
      3: begin ref_mem[ea] = acv; push_tx(1'b1, ea, acv); exp_md = acv; end
      4: begin
        v = pcv + 12'd1; ref_mem[ea] = v; push_tx(1'b1, ea, v);
        exp_md = v; exp_jump = 1; nxt = ptr + 12'd1; exp_ea = {fld, nxt};
      end
      default: exp_jump = 1;
    endcase
  endtask

  task automatic compare_q(input string tag);
    check_eq({tag, "_ntx"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq({tag, "_tx"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_finish(input string tag, input bit poke);
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      examd = poke && busy && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    examd = 1'b0;
    check_eq({tag, "_done"}, 32'(done), 32'(1));
    check_eq({tag, "_skip"}, 32'(skip), 32'(exp_skip));
    check_eq({tag, "_jump"}, 32'(jump), 32'(exp_jump));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'(0));
    check_eq({tag, "_idle"}, 32'(busy), 32'(0));
    check_eq({tag, "_md"}, 32'(mdout), 32'(exp_md));
    if (chk_ea) check_eq({tag, "_ea"}, 32'(eaddr), 32'(exp_ea));
    compare_q(tag);
  endtask

  task automatic run_memref(input string tag, input logic [11:0] ins, input logic [11:0] pcv,
                            input logic [11:0] acv, input logic [FW-1:0] ifv,
                            input logic [FW-1:0] dfv, input bit poke);
    model_memref(ins, pcv, acv, ifv, dfv);
    instruction = ins; pc = pcv; ac = acv; IF = ifv; DF = dfv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(tag, poke);
  endtask

  // kind: 0 load address, 1 deposit, 2 examine
  task automatic run_panel(input string tag, input int kind, input logic [11:0] srv,
                           input logic [FW-1:0] ifv);
    logic [11:0] lo;
    sr = srv; IF = ifv;
    exp_skip = 0; exp_jump = 0; chk_ea = 0;
    if (kind == 0) begin
      exp_panel = {ifv, srv};
      addr_loadd = 1'b1;
      @(negedge clk);
      addr_loadd = 1'b0;
      check_eq({tag, "_ld_busy"}, 32'(busy), 32'(0));
      check_eq({tag, "_ld_ea"}, 32'(eaddr), 32'(exp_panel));
      compare_q(tag);
      return;
    end
    if (kind == 1) begin
      ref_mem[exp_panel] = srv;
      push_tx(1'b1, exp_panel, srv);
      exp_md = srv;
      depd = 1'b1;
    end else begin
      push_tx(1'b0, exp_panel, ref_mem[exp_panel]);
      exp_md = ref_mem[exp_panel];
      examd = 1'b1;
    end
    lo = exp_panel[11:0] + 12'd1;
    exp_panel = {exp_panel[AW-1:12], lo};
    @(negedge clk);
    depd = 1'b0; examd = 1'b0;
    wait_finish(tag, 1'b0);
  endtask

  initial begin
    logic [11:0] ins, v;
    bit          seen_done, seen_req;
    int          cyc;

    reset = 1'b1; start = 0; addr_loadd = 0; depd = 0; examd = 0;
    instruction = '0; pc = '0; ac = '0; sr = '0; IF = '0; DF = '0;
    for (int i = 0; i < 32768; i++) begin
      v = 12'($urandom);
      bus_mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(mem_req), 32'(0));
    check_eq("rst_we", 32'(mem_we), 32'(0));
    check_eq("rst_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_wdata", 32'(mem_wdata), 32'(0));
    check_eq("rst_outs", 32'({eaddr, mdout, skip, jump, busy, done}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // TAD direct, current page
    lat = 1;
    set_mem(15'o00250, 12'o1234);
    run_memref("tad", 12'o1250, 12'o0200, 12'o0000, 3'd0, 3'd0, 1'b0);
    check_eq("tad_md_const", 32'(mdout), 32'(12'o1234));

    // ISZ indirect through an auto-index pointer
    set_mem(15'o00010, 12'o0477);
    set_mem(15'o20500, 12'o7777);
    run_memref("isz_ai", 12'o2410, 12'o3000, 12'o0000, 3'd0, 3'd2, 1'b0);
    check_eq("isz_ea_const", 32'(eaddr), 32'(15'o20500));
    check_eq("isz_ptr_mem", 32'(bus_mem[15'o00010]), 32'(12'o0500));

    // JMS with a slow memory
    lat = 3;
    run_memref("jms", 12'o4300, 12'o0200, 12'o0000, 3'd1, 3'd0, 1'b0);
    check_eq("jms_ea_const", 32'(eaddr), 32'(15'o10301));
    check_eq("jms_mem", 32'(bus_mem[15'o10300]), 32'(12'o0201));
    lat = 1;

    // Panel load, two deposits wrapping the low 12 bits, examine
    set_mem(15'o00001, 12'o4567);
    run_panel("pload", 0, 12'o7777, 3'd0);
    run_panel("pdep1", 1, 12'o1111, 3'd0);
    run_panel("pdep2", 1, 12'o2222, 3'd0);
    run_panel("pexam", 2, 12'o0000, 3'd0);
    check_eq("pdep1_mem", 32'(bus_mem[15'o07777]), 32'(12'o1111));
    check_eq("pdep2_mem", 32'(bus_mem[15'o00000]), 32'(12'o2222));
    check_eq("pexam_md", 32'(mdout), 32'(12'o4567));

    // Reset while an operand read is waiting on the bus
    resp_en = 0;
    instruction = 12'o1250; pc = 12'o0200; IF = '0; DF = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_req = 0;
    for (int i = 0; i < 10 && !seen_req; i++) begin
      if (mem_req) seen_req = 1;
      else @(negedge clk);
    end
    check_eq("mid_req_up", 32'(seen_req), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_req", 32'(mem_req), 32'(0));
    check_eq("mid_busy", 32'(busy), 32'(0));
    check_eq("mid_done", 32'(done), 32'(0));
    check_eq("mid_outs", 32'({eaddr, mdout, skip, jump}), 32'(0));
    exp_md = '0; exp_ea = '0; exp_panel = '0;
    force_ack = 1;
    resp_en = 1;
    seen_done = 0; seen_req = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) force_ack = 0;
      if (done) seen_done = 1;
      if (mem_req) seen_req = 1;
    end
    force_ack = 0;
    check_eq("mid_no_done", 32'(seen_done), 32'(0));
    check_eq("mid_no_req", 32'(seen_req), 32'(0));
    compare_q("mid");

    // OPR start with a simultaneous deposit pulse
    model_memref(12'o7000, 12'o0100, 12'o0000, 3'd0, 3'd0);
    instruction = 12'o7000; pc = 12'o0100; sr = 12'o5555; start = 1'b1; depd = 1'b1;
    @(negedge clk);
    start = 1'b0; depd = 1'b0;
    check_eq("opr_done", 32'(done), 32'(1));
    check_eq("opr_skip", 32'(skip), 32'(0));
    check_eq("opr_jump", 32'(jump), 32'(0));
    @(negedge clk);
    check_eq("opr_done_pulse", 32'(done), 32'(0));
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    check_eq("opr_idle", 32'(cyc), 32'(0));
    check_eq("opr_md", 32'(mdout), 32'(exp_md));
    compare_q("opr");

    // Random traffic with random latency and panel pulses dropped while busy
    rand_lat = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        run_panel("rpanel", int'($urandom_range(0, 2)), 12'($urandom), 3'($urandom));
      end else begin
        ins = 12'($urandom);
        if ($urandom_range(0, 3) == 0) ins[8:0] = {2'b10, 7'($urandom_range(8, 15))};
        run_memref("rand", ins, 12'($urandom), 12'($urandom), 3'($urandom), 3'($urandom), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
